date_set_ctrl: RTL and testbench
================================

Name: date_set_ctrl

Overview:
- Controller that arbitrates the enable inputs of the day, month and year counters between two sources: the running carry chain, and a two-button user set mode.
- Sits between the hour counter's rollover output and the day/month/year blocks.
- In RUN it passes carries through. In set states it freezes the chain and steps only the selected field.
- Also provides field-select and blink outputs for the 7-seg display driver.

Parameters:
- HOLD_CYC, 25_000_000, cycles btn_up must be held before auto-repeat starts.
- REPEAT_CYC, 5_000_000, cycles between auto-repeat pulses while held.
- TIMEOUT_CYC, 500_000_000, idle cycles in a set state before forced return to RUN.
- BLINK_CYC, 12_500_000, half-period of the blink toggle (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- hh_to_dd_en  in  1  day-advance pulse from the hour counter rollover
- dd_to_mm_en  in  1  carry pulse from the day block
- mm_to_yy_en  in  1  carry pulse from the month block
- btn_mode  in  1  mode button; synchronous, debounced level
- btn_up  in  1  increment button; synchronous, debounced level
- day_en  out  1  enable to the day block
- month_en  out  1  enable to the month block
- year_en  out  1  enable to the year block
- run  out  1  1 in RUN; gates the sec/min/hour chain
- sel  out  2  0=RUN, 1=SET_DAY, 2=SET_MONTH, 3=SET_YEAR
- blink  out  3  blank mask: [0]=day, [1]=month, [2]=year; 1 = blank the field

Behaviour:
- Reset (rst=0, async): state RUN; all internal counters 0; btn edge registers 0; day_en/month_en/year_en=0; run=1; sel=0; blink=0.
- FSM states: RUN, SET_DAY, SET_MONTH, SET_YEAR.
  - A btn_mode rising edge advances the state: RUN->SET_DAY->SET_MONTH->SET_YEAR->RUN.
  - The state changes at the clock edge that samples the edge.
  - Edge = current level 1, previous registered level 0.
- RUN, combinational pass-through with zero latency:
  - day_en = hh_to_dd_en
  - month_en = dd_to_mm_en
  - year_en = mm_to_yy_en
  - btn_up is ignored.
- Set states:
  - All carry inputs are ignored; run=0.
  - Only the selected field's enable may pulse. The other two enables are held 0.
  - Consequence: a day wrap 31->01 does not advance the month.
- Increment pulse:
  - btn_up rising edge sampled at edge N -> registered 1-cycle pulse on the selected enable during cycle N+1.
  - Auto-repeat: while btn_up stays 1, a repeat counter runs.
    - First repeat pulse: HOLD_CYC cycles after the initial pulse.
    - Subsequent pulses: every REPEAT_CYC cycles.
    - Release clears the counter.
- Simultaneous events:
  - btn_mode edge and btn_up activity in the same cycle: mode wins; no increment pulse is issued, and the repeat counter is cleared.
  - Carry arriving in the same cycle as the RUN->SET_DAY transition: still passed through (state is RUN that cycle).
- Timeout:
  - Counter is cleared in RUN, on any button edge, and while btn_up is held.
  - In a set state, reaching TIMEOUT_CYC-1 forces RUN on the next edge with no enable pulse.
- Counter widths are $clog2(param+1). Counters saturate; they never wrap.
- sel is registered and equals the state encoding.
- Mid-operation reset returns to RUN immediately; no partial pulse is emitted after reset release.

Optional Feature:
- Macro DATE_SET_BLINK_EN.
- Defined:
  - A free-running BLINK_CYC toggle drives the selected field's blink bit with a 50% duty cycle.
  - The toggle is forced to 0 (field visible) while btn_up=1.
  - blink=0 in RUN.
- Undefined:
  - No blink counter.
  - blink=0 always.
  - The display uses sel alone.

Decomposition:
- Package date_ctrl_pkg holds:
  - state encoding localparams (ST_RUN=0, ST_DAY=1, ST_MONTH=2, ST_YEAR=3)
  - blink bit indices (BL_DAY=0, BL_MONTH=1, BL_YEAR=2)
- Sub-module btn_edge_repeat (params HOLD_CYC, REPEAT_CYC):
  - in: clk, rst, btn, clr
  - out: pulse
  - Instantiated once for btn_up.
  - btn_mode uses a plain edge register.

Test Plan (override HOLD_CYC=8, REPEAT_CYC=3, TIMEOUT_CYC=40, BLINK_CYC=4):
- RUN pass-through: hh_to_dd_en, dd_to_mm_en, mm_to_yy_en each pulsed for 1 cycle -> day_en, month_en, year_en high in the same cycle; run=1, sel=0.
- Mode cycling: 4 btn_mode presses -> sel sequence 1,2,3,0, each changing the edge after the press. In SET_DAY, hh_to_dd_en=1 -> day_en stays 0, run=0.
- Single increment:
  - In SET_MONTH, btn_up 0->1 at edge N held 2 cycles -> month_en=1 for exactly cycle N+1; day_en=year_en=0.
  - dd_to_mm_en=1 injected -> month_en unaffected.
- Auto-repeat: in SET_YEAR, hold btn_up for 20 cycles -> year_en pulses at N+1, N+9, N+12, N+15, N+18; release -> no further pulses.
- Timeout and collision:
  - In SET_DAY with no buttons for 40 cycles -> sel=0 and run=1; no enable pulse.
  - btn_mode and btn_up rising in the same cycle -> state advances, no increment pulse.
- Async reset: assert rst=0 mid auto-repeat in SET_YEAR -> sel=0, run=1, enables 0 immediately. After release with btn_up still high -> no pulse until a fresh rising edge.

Source files
------------

// File: rtl/date_ctrl_pkg.sv
// rtl/date_ctrl_pkg.sv - shared state encoding, blink bit indices and helpers for date_set_ctrl
package date_ctrl_pkg;

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_DAY   = 2'd1;
   localparam logic [1:0] ST_MONTH = 2'd2;
   localparam logic [1:0] ST_YEAR  = 2'd3;

   localparam int BL_DAY   = 0;
   localparam int BL_MONTH = 1;
   localparam int BL_YEAR  = 2;

   function automatic logic [1:0] next_state(input logic [1:0] st);
      logic [1:0] nxt;
      case (st)
         ST_RUN:   nxt = ST_DAY;
         ST_DAY:   nxt = ST_MONTH;
         ST_MONTH: nxt = ST_YEAR;
         default:  nxt = ST_RUN;
      endcase
      return nxt;
   endfunction

   // Display field owned by a set state; RUN owns no field.
   function automatic logic [2:0] field_mask(input logic [1:0] st);
      logic [2:0] m;
      m = 3'b000;
      case (st)
         ST_DAY:   m[BL_DAY]   = 1'b1;
         ST_MONTH: m[BL_MONTH] = 1'b1;
         ST_YEAR:  m[BL_YEAR]  = 1'b1;
         default:  m = 3'b000;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/btn_edge_repeat.sv
// rtl/btn_edge_repeat.sv - button rising-edge pulse with hold-to-auto-repeat
module btn_edge_repeat #(
   parameter int HOLD_CYC   = 25_000_000,
   parameter int REPEAT_CYC = 5_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   input  logic clr,
   output logic pulse
);

   localparam int CW = $clog2(HOLD_CYC + 1);
   localparam logic [CW-1:0] FIRE   = CW'(HOLD_CYC - 1);
   localparam logic [CW-1:0] RELOAD = CW'(HOLD_CYC - REPEAT_CYC);
   localparam logic [CW-1:0] CMAX   = {CW{1'b1}};

   logic          btn_q;
   logic          armed;
   logic          rise;
   logic [CW-1:0] cnt;

   assign rise = btn & ~btn_q;

   // Repeats only follow an accepted press, so a button already held when
   // clr drops (or after reset) stays silent until it is pressed again.
   // Reloading to HOLD-REPEAT makes every later repeat reuse the FIRE compare.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         btn_q <= 1'b0;
         armed <= 1'b0;
         cnt   <= '0;
         pulse <= 1'b0;
      end else begin
         btn_q <= btn;
         pulse <= 1'b0;
         if (clr || !btn) begin
            armed <= 1'b0;
            cnt   <= '0;
         end else if (rise) begin
            armed <= 1'b1;
            cnt   <= '0;
            pulse <= 1'b1;
         end else if (armed) begin
            if (cnt == FIRE) begin
               pulse <= 1'b1;
               cnt   <= RELOAD;
            end else if (cnt != CMAX) begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/date_set_ctrl.sv
// rtl/date_set_ctrl.sv - day/month/year enable arbiter between carry chain and two-button set mode
// Optional field blinking is built when DATE_SET_BLINK_EN is defined.
module date_set_ctrl
   import date_ctrl_pkg::*;
#(
   parameter int HOLD_CYC    = 25_000_000,
   parameter int REPEAT_CYC  = 5_000_000,
   parameter int TIMEOUT_CYC = 500_000_000,
   parameter int BLINK_CYC   = 12_500_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       hh_to_dd_en,
   input  logic       dd_to_mm_en,
   input  logic       mm_to_yy_en,
   input  logic       btn_mode,
   input  logic       btn_up,
   output logic       day_en,
   output logic       month_en,
   output logic       year_en,
   output logic       run,
   output logic [1:0] sel,
   output logic [2:0] blink
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
   localparam logic [TW-1:0] TO_SAT  = TW'(TIMEOUT_CYC);

   logic [1:0]    state;
   logic          mode_q;
   logic          mode_rise;
   logic          in_run;
   logic          timeout;
   logic          up_pulse;
   logic [TW-1:0] to_cnt;

   assign mode_rise = btn_mode & ~mode_q;
   assign in_run    = (state == ST_RUN);
   assign timeout   = ~in_run & ~mode_rise & ~btn_up & (to_cnt == TO_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= ST_RUN;
         mode_q <= 1'b0;
         to_cnt <= '0;
      end else begin
         mode_q <= btn_mode;
         if (mode_rise) begin
            state <= next_state(state);
         end else if (timeout) begin
            state <= ST_RUN;
         end
         if (in_run || mode_rise || btn_up) begin
            to_cnt <= '0;
         end else if (to_cnt != TO_SAT) begin
            to_cnt <= to_cnt + 1'b1;
         end
      end
   end

   // A mode press in the same cycle as btn_up swallows the increment.
   btn_edge_repeat #(
      .HOLD_CYC   (HOLD_CYC),
      .REPEAT_CYC (REPEAT_CYC)
   ) u_up (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn_up),
      .clr   (in_run | mode_rise),
      .pulse (up_pulse)
   );

   always_comb begin
      day_en   = 1'b0;
      month_en = 1'b0;
      year_en  = 1'b0;
      if (in_run) begin
         day_en   = hh_to_dd_en;
         month_en = dd_to_mm_en;
         year_en  = mm_to_yy_en;
      end else begin
         day_en   = (state == ST_DAY)   & up_pulse;
         month_en = (state == ST_MONTH) & up_pulse;
         year_en  = (state == ST_YEAR)  & up_pulse;
      end
   end

   assign run = in_run;
   assign sel = state;

`ifdef DATE_SET_BLINK_EN
   localparam int BW = $clog2(BLINK_CYC + 1);
   localparam logic [BW-1:0] BL_LAST = BW'(BLINK_CYC - 1);

   logic [BW-1:0] bl_cnt;
   logic          bl_tog;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bl_cnt <= '0;
         bl_tog <= 1'b0;
      end else if (bl_cnt == BL_LAST) begin
         bl_cnt <= '0;
         bl_tog <= ~bl_tog;
      end else begin
         bl_cnt <= bl_cnt + 1'b1;
      end
   end

   // Keep the field visible while the user is stepping it.
   assign blink = (bl_tog && !btn_up) ? field_mask(state) : 3'b000;
`else
   assign blink = 3'b000;
`endif

endmodule

// File: tb/tb_date_set_ctrl.sv
// tb/tb_date_set_ctrl.sv - randomized self-checking bench for date_set_ctrl against a behavioural model
module tb_date_set_ctrl;

   localparam int HOLD = 8;
   localparam int REP  = 3;
   localparam int TMO  = 40;
   localparam int BLK  = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       hh_to_dd_en = 1'b0;
   logic       dd_to_mm_en = 1'b0;
   logic       mm_to_yy_en = 1'b0;
   logic       btn_mode = 1'b0;
   logic       btn_up = 1'b0;
   logic       day_en, month_en, year_en, run;
   logic [1:0] sel;
   logic [2:0] blink;

   int n_checks = 0;
   int n_pass   = 0;

   // model: mode index 0=RUN..3=YEAR, hold length since accepted press (-1 = none)
   int   m_state, m_idle, m_held, m_pulse, m_edges;
   logic m_mode_prev, m_up_prev;
   logic [2:0] last_en;

   date_set_ctrl #(
      .HOLD_CYC    (HOLD),
      .REPEAT_CYC  (REP),
      .TIMEOUT_CYC (TMO),
      .BLINK_CYC   (BLK)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .hh_to_dd_en (hh_to_dd_en),
      .dd_to_mm_en (dd_to_mm_en),
      .mm_to_yy_en (mm_to_yy_en),
      .btn_mode    (btn_mode),
      .btn_up      (btn_up),
      .day_en      (day_en),
      .month_en    (month_en),
      .year_en     (year_en),
      .run         (run),
      .sel         (sel),
      .blink       (blink)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic model_reset();
      m_state = 0; m_idle = 0; m_held = -1; m_pulse = 0; m_edges = 0;
      m_mode_prev = 1'b0; m_up_prev = 1'b0;
   endtask

   task automatic model_edge(input logic bm, input logic bu);
      logic mr, ur;
      int   nxt;
      mr  = bm && !m_mode_prev;
      ur  = bu && !m_up_prev;
      nxt = 0;
      if (mr) begin
         m_state = (m_state + 1) % 4; m_idle = 0; m_held = -1;
      end else if (m_state == 0) begin
         m_idle = 0; m_held = -1;
      end else if (bu) begin
         m_idle = 0;
         if (ur) begin
            m_held = 0; nxt = 1;
         end else if (m_held >= 0) begin
            m_held++;
            if (m_held == HOLD || (m_held > HOLD && (m_held - HOLD) % REP == 0)) nxt = 1;
         end
      end else begin
         m_held = -1;
         if (m_idle == TMO - 1) m_state = 0;
         else m_idle++;
      end
      m_pulse = nxt; m_mode_prev = bm; m_up_prev = bu; m_edges++;
   endtask

   // Called just after a falling edge: drive, compare, then advance the model on the rising edge.
   task automatic apply(input logic hh, input logic dm, input logic my, input logic bm, input logic bu);
      logic       e_run;
      logic [2:0] e_blink;
      hh_to_dd_en = hh; dd_to_mm_en = dm; mm_to_yy_en = my; btn_mode = bm; btn_up = bu;
      #1;
      e_run = (m_state == 0);
      e_blink = 3'b000;
`ifdef DATE_SET_BLINK_EN
      if (!e_run && !bu && ((m_edges / BLK) % 2 == 1)) e_blink = 3'b001 << (m_state - 1);
`endif
      chk("sel", 32'(sel), 32'(m_state));
      chk("run", 32'(run), 32'(e_run));
      chk("day_en", 32'(day_en), 32'(e_run ? hh : (m_state == 1 && m_pulse != 0)));
      chk("month_en", 32'(month_en), 32'(e_run ? dm : (m_state == 2 && m_pulse != 0)));
      chk("year_en", 32'(year_en), 32'(e_run ? my : (m_state == 3 && m_pulse != 0)));
      chk("blink", 32'(blink), 32'(e_blink));
      last_en = {year_en, month_en, day_en};
      @(posedge clk);
      model_edge(bm, bu);
   endtask

   task automatic step(input logic hh, input logic dm, input logic my, input logic bm, input logic bu);
      @(negedge clk);
      apply(hh, dm, my, bm, bu);
   endtask

   task automatic press();
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0);
   endtask

   initial begin
      int   cnt;
      int   pos[$];
      int   exp_pos[5];
      logic r_bu;
      exp_pos = '{1, 9, 12, 15, 18};
      model_reset();
      #1;
      chk("rst_sel", 32'(sel), 32'd0);
      chk("rst_run", 32'(run), 32'd1);
      chk("rst_en", 32'({year_en, month_en, day_en}), 32'd0);
      chk("rst_blink", 32'(blink), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      apply(0, 0, 0, 0, 0);

      step(1, 0, 0, 0, 0);
      chk("pass_day", 32'(last_en), 32'b001);
      step(0, 1, 0, 0, 0);
      chk("pass_month", 32'(last_en), 32'b010);
      step(0, 0, 1, 0, 0);
      chk("pass_year", 32'(last_en), 32'b100);

      for (int k = 1; k <= 4; k++) begin
         step(0, 0, 0, 1, 0);
         #1 chk("mode_seq", 32'(sel), 32'(k % 4));
         if (k == 1) begin
            step(1, 0, 0, 0, 0);
            chk("setday_block", 32'(last_en), 32'd0);
         end
         step(0, 0, 0, 0, 0);
      end

      press(); press();
      cnt = 0;
      step(0, 1, 0, 0, 1); cnt += int'(last_en[1]);
      step(0, 1, 0, 0, 1); cnt += int'(last_en[1]);
      chk("inc_other_en", 32'({last_en[2], last_en[0]}), 32'd0);
      for (int i = 0; i < 4; i++) begin
         step(0, 1, 0, 0, 0); cnt += int'(last_en[1]);
      end
      chk("inc_month_cnt", 32'(cnt), 32'd1);

      press();
      for (int i = 0; i < 20; i++) begin
         step(0, 0, 0, 0, 1);
         if (last_en[2]) pos.push_back(i);
      end
      chk("rep_count", 32'(pos.size()), 32'd5);
      for (int i = 0; i < 5 && i < pos.size(); i++) chk("rep_pos", 32'(pos[i]), 32'(exp_pos[i]));
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         step(0, 0, 0, 0, 0); cnt += int'(last_en[2]);
      end
      chk("rep_release", 32'(cnt), 32'd0);

      press(); press();
      cnt = 0;
      for (int i = 0; i < TMO - 2; i++) begin
         step(0, 0, 0, 0, 0); cnt += int'(last_en[0]);
      end
      #1 chk("tmo_before", 32'(sel), 32'd1);
      step(0, 0, 0, 0, 0);
      #1 chk("tmo_sel", 32'(sel), 32'd0);
      chk("tmo_run", 32'(run), 32'd1);
      chk("tmo_no_pulse", 32'(cnt), 32'd0);

      press();
      step(0, 0, 0, 1, 1);
      #1 chk("collide_sel", 32'(sel), 32'd2);
      cnt = 0;
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 0, 0, 0); cnt += int'(last_en[1]);
      end
      chk("collide_no_inc", 32'(cnt), 32'd0);

      press();
      for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 1);
      @(negedge clk);
      hh_to_dd_en = 0; dd_to_mm_en = 0; mm_to_yy_en = 0; btn_mode = 0;
      rst = 1'b0;
      #1;
      chk("arst_sel", 32'(sel), 32'd0);
      chk("arst_run", 32'(run), 32'd1);
      chk("arst_en", 32'({year_en, month_en, day_en}), 32'd0);
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      apply(0, 0, 0, 0, 1);
      step(0, 0, 0, 1, 1);
      cnt = 0;
      for (int i = 0; i < 14; i++) begin
         step(0, 0, 0, 0, 1); cnt += int'(last_en[0]);
      end
      chk("arst_held_silent", 32'(cnt), 32'd0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0);
      chk("arst_fresh_press", 32'(last_en), 32'b001);

      r_bu = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 11) == 0) r_bu = ~r_bu;
         step($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
              $urandom_range(0, 24) == 0, r_bu);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
